// File: rtl/mod_down_counter.sv
// rtl/mod_down_counter.sv - loadable modulo down-counter with terminal-count pulse and optional auto-reload
// Optional Gray-coded count output enabled by defining MOD_DOWN_COUNTER_GRAY_EN.
module mod_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_rl,
    output logic [WIDTH-1:0] q,
`ifdef MOD_DOWN_COUNTER_GRAY_EN
    output logic [WIDTH-1:0] q_gray,
`endif
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_reload;
    logic             r_tc;

    state_t           w_state_next;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_reload_next;
    logic             w_tc_next;

    // Load outranks everything; RUN with q==0 is never entered, so q-1 cannot wrap.
    always_comb begin
        w_state_next  = r_state;
        w_q_next      = r_q;
        w_reload_next = r_reload;
        w_tc_next     = 1'b0;
        if (load) begin
            w_q_next      = load_val;
            w_reload_next = load_val;
            if (load_val != '0) begin
                w_state_next = RUN;
            end else begin
                w_state_next = DONE;
                w_tc_next    = 1'b1;
            end
        end else begin
            case (r_state)
                RUN: begin
                    if (en) begin
                        if (r_q == WIDTH'(1)) begin
                            w_tc_next = 1'b1;
                            if (auto_rl) begin
                                w_q_next = r_reload;
                            end else begin
                                w_q_next     = '0;
                                w_state_next = DONE;
                            end
                        end else begin
                            w_q_next = r_q - WIDTH'(1);
                        end
                    end
                end
                DONE:    w_q_next = '0;
                default: w_q_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_q      <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_q      <= w_q_next;
            r_reload <= w_reload_next;
            r_tc     <= w_tc_next;
        end
    end

`ifdef MOD_DOWN_COUNTER_GRAY_EN
    logic [WIDTH-1:0] r_q_gray;

    // Encoded from the next count so the Gray value lands on the same edge as q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q_gray <= '0;
        end else begin
            r_q_gray <= w_q_next ^ (w_q_next >> 1);
        end
    end

    assign q_gray = r_q_gray;
`endif

    assign q    = r_q;
    assign tc   = r_tc;
    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);

endmodule

// File: tb/tb_mod_down_counter.sv
// tb/tb_mod_down_counter.sv - directed self-checking bench for mod_down_counter
// Covers the Gray output when MOD_DOWN_COUNTER_GRAY_EN is defined.
module tb_mod_down_counter;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic             en = 1'b0;
    logic             auto_rl = 1'b0;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             busy;
    logic             done;
`ifdef MOD_DOWN_COUNTER_GRAY_EN
    logic [WIDTH-1:0] q_gray;
`endif

    int n_pass  = 0;
    int n_total = 0;

    mod_down_counter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .auto_rl  (auto_rl),
        .q        (q),
`ifdef MOD_DOWN_COUNTER_GRAY_EN
        .q_gray   (q_gray),
`endif
        .tc       (tc),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [WIDTH-1:0] eq, input logic etc,
                           input logic ebusy, input logic edone);
        chk({tag, ".q"},    16'(q),    16'(eq));
        chk({tag, ".tc"},   16'(tc),   16'(etc));
        chk({tag, ".busy"}, 16'(busy), 16'(ebusy));
        chk({tag, ".done"}, 16'(done), 16'(edone));
    endtask

    initial begin
        logic [WIDTH-1:0] eq;
        logic             etc;
        int               tc_cnt;

        step();
        step();
        chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);
`ifdef MOD_DOWN_COUNTER_GRAY_EN
        chk("reset.q_gray", 16'(q_gray), 16'd0);
`endif
        rst = 1'b0;

        // IDLE ignores en
        en = 1'b1;
        step();
        step();
        chk_all("idle_en", 4'd0, 1'b0, 1'b0, 1'b0);

        // async reset mid-RUN
        en = 1'b0; load = 1'b1; load_val = 4'd5;
        step();
        load = 1'b0;
        chk_all("pre_rst", 4'd5, 1'b0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 4'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        chk_all("post_rst", 4'd0, 1'b0, 1'b0, 1'b0);

        // one-shot from 3
        load = 1'b1; load_val = 4'd3; en = 1'b1; auto_rl = 1'b0;
        step();
        load = 1'b0;
        chk_all("os_3", 4'd3, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("os_2", 4'd2, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("os_1", 4'd1, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("os_0", 4'd0, 1'b1, 1'b0, 1'b1);
        auto_rl = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_all("os_hold", 4'd0, 1'b0, 1'b0, 1'b1);
        end

        // auto-reload period 4
        load = 1'b1; load_val = 4'd4; auto_rl = 1'b1; en = 1'b1;
        step();
        load = 1'b0;
        chk_all("ar_load", 4'd4, 1'b0, 1'b1, 1'b0);
        eq = 4'd4;
        tc_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            etc = (eq == 4'd1);
            eq  = (eq == 4'd1) ? 4'd4 : eq - 4'd1;
            step();
            if (tc) tc_cnt++;
            chk_all("ar_run", eq, etc, 1'b1, 1'b0);
        end
        chk("ar_tc_count", 16'(tc_cnt), 16'd5);

        // enable gating then zero load
        load = 1'b1; load_val = 4'd2; auto_rl = 1'b0; en = 1'b0;
        step();
        load = 1'b0;
        chk_all("eg_2", 4'd2, 1'b0, 1'b1, 1'b0);
        en = 1'b1;
        step();
        chk_all("eg_en1", 4'd1, 1'b0, 1'b1, 1'b0);
        en = 1'b0;
        step();
        chk_all("eg_en0a", 4'd1, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("eg_en0b", 4'd1, 1'b0, 1'b1, 1'b0);
        en = 1'b1;
        step();
        chk_all("eg_tc", 4'd0, 1'b1, 1'b0, 1'b1);
        en = 1'b0; load = 1'b1; load_val = 4'd0;
        step();
        load = 1'b0;
        chk_all("zero_load", 4'd0, 1'b1, 1'b0, 1'b1);
        step();
        chk_all("zero_after", 4'd0, 1'b0, 1'b0, 1'b1);

        // load collides with terminal count
        load = 1'b1; load_val = 4'd2; en = 1'b1;
        step();
        load = 1'b0;
        step();
        chk_all("col_pre", 4'd1, 1'b0, 1'b1, 1'b0);
        load = 1'b1; load_val = 4'd9;
        step();
        load = 1'b0; en = 1'b0;
        chk_all("col", 4'd9, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("col_hold", 4'd9, 1'b0, 1'b1, 1'b0);

`ifdef MOD_DOWN_COUNTER_GRAY_EN
        load = 1'b1; load_val = 4'd15; en = 1'b1; auto_rl = 1'b0;
        step();
        load = 1'b0;
        chk("gray_15", 16'(q_gray), 16'd8);
        eq = 4'd15;
        for (int i = 0; i < 15; i++) begin
            eq = eq - 4'd1;
            step();
            chk("gray_q", 16'(q), 16'(eq));
            chk("gray_code", 16'(q_gray), 16'(eq ^ (eq >> 1)));
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
